// File: rtl/clkrst_pkg.sv
// Shared types and default sizing for the clock/reset sequencer.
//   state_e      : sequencer FSM states
//   *_DEF        : default values for the clkrst_seq / ce_div parameters
package clkrst_pkg;

    localparam int unsigned N_CH_DEF    = 4;
    localparam int unsigned RST_CYC_DEF = 16;
    localparam int unsigned STAGGER_DEF = 8;
    localparam int unsigned DIV_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ASSERT  = 2'd3
    } state_e;

endpackage

// File: rtl/ce_div.sv
// Per-channel clock-enable divider.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_en    : next-cycle enable (the D input of the channel's reset-release flop)
//   i_ratio : divide ratio, latched on enable and at every wrap
//   o_ce    : registered clock-enable pulse, one cycle every ratio cycles
module ce_div
    import clkrst_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_ce
);

    logic             r_active;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;
    logic [DIV_W-1:0] w_term;

    // Ratios 0 and 1 both mean "every cycle", so the terminal count is 0.
    always_comb begin
        w_term = (r_ratio <= DIV_W'(1)) ? '0 : r_ratio - DIV_W'(1);
    end

    // Enable is taken one cycle early so the divider starts on the release edge itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_ratio  <= '0;
            r_cnt    <= '0;
            r_ce     <= 1'b0;
        end else begin
            r_active <= i_en;
            if (!i_en) begin
                r_cnt <= '0;
                r_ce  <= 1'b0;
            end else if (!r_active) begin
                r_ratio <= i_ratio;
                r_cnt   <= '0;
                r_ce    <= (i_ratio <= DIV_W'(1));
            end else if (r_cnt == w_term) begin
                r_ratio <= i_ratio;
                r_cnt   <= '0;
                r_ce    <= 1'b1;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
                r_ce  <= 1'b0;
            end
        end
    end

    assign o_ce = r_ce;

endmodule

// File: rtl/clkrst_seq.sv
// Staggered reset-release sequencer with per-channel clock-enable dividers.
//   CLK      : clock
//   RST      : synchronous active-high reset
//   SRST_REQ : soft-reset request, honoured only in RUN
//   SRST_ACK : one-cycle acknowledge of an accepted soft reset
//   DIV      : per-channel divide ratios, channel i at [i*DIV_W +: DIV_W]
//   CH_RSTn  : per-channel active-low resets
//   CH_CE    : per-channel clock-enable pulses
//   READY    : all channels released and sequencer in RUN
module clkrst_seq
    import clkrst_pkg::*;
#(
    parameter int unsigned N_CH    = N_CH_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned STAGGER = STAGGER_DEF,
    parameter int unsigned DIV_W   = DIV_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SRST_REQ,
    output logic                  SRST_ACK,
    input  logic [N_CH*DIV_W-1:0] DIV,
    output logic [N_CH-1:0]       CH_RSTn,
    output logic [N_CH-1:0]       CH_CE,
    output logic                  READY
);

    localparam int unsigned LAST_REL = (N_CH - 1) * STAGGER;
    localparam int unsigned CNT_MAX  = (RST_CYC > LAST_REL) ? RST_CYC : LAST_REL;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_e            r_state;
    state_e            w_state_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [N_CH-1:0]   r_rstn;
    logic [N_CH-1:0]   w_rstn_d;
    logic              r_ack;
    logic              w_ack_d;
    logic              r_ready;
    logic              w_ready_d;

    // State, shared counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_rstn  <= '0;
            r_ack   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rstn  <= w_rstn_d;
            r_ack   <= w_ack_d;
            r_ready <= w_ready_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rstn_d  = r_rstn;
        w_ack_d   = 1'b0;
        w_ready_d = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_rstn_d = '0;
                if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                    w_state_d = ST_RELEASE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Releases are sticky; with STAGGER=0 every channel matches count 0.
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (r_cnt == CNT_W'(i * STAGGER)) begin
                        w_rstn_d[i] = 1'b1;
                    end
                end
                if (r_cnt == CNT_W'(LAST_REL)) begin
                    w_state_d = ST_RUN;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (SRST_REQ) begin
                    w_state_d = ST_ASSERT;
                    w_rstn_d  = '0;
                    w_ack_d   = 1'b1;
                end else begin
                    w_ready_d = &r_rstn;
                end
            end
            ST_ASSERT: begin
                w_rstn_d  = '0;
                w_state_d = ST_HOLD;
                w_cnt_d   = '0;
            end
            default: begin
                w_rstn_d  = '0;
                w_state_d = ST_HOLD;
                w_cnt_d   = '0;
            end
        endcase
    end

    // One divider per channel, enabled in step with its reset release.
    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        ce_div #(
            .DIV_W (DIV_W)
        ) u_ce_div (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_en    (w_rstn_d[g]),
            .i_ratio (DIV[g*DIV_W +: DIV_W]),
            .o_ce    (CH_CE[g])
        );
    end

    assign CH_RSTn  = r_rstn;
    assign SRST_ACK = r_ack;
    assign READY    = r_ready;

endmodule

// File: tb/tb_clkrst_seq.sv
// Directed self-checking bench for clkrst_seq: default instance plus a
// STAGGER=0 / RST_CYC=4 instance sharing clock and reset.
module tb_clkrst_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        srst_a, srst_b;
    logic [31:0] div_a, div_b;
    logic [3:0]  rstn_a, ce_a, rstn_b, ce_b;
    logic        ack_a, ready_a, ack_b, ready_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    clkrst_seq u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .SRST_REQ (srst_a),
        .SRST_ACK (ack_a),
        .DIV      (div_a),
        .CH_RSTn  (rstn_a),
        .CH_CE    (ce_a),
        .READY    (ready_a)
    );

    clkrst_seq #(
        .N_CH    (4),
        .RST_CYC (4),
        .STAGGER (0),
        .DIV_W   (8)
    ) u_dut_s0 (
        .CLK      (CLK),
        .RST      (RST),
        .SRST_REQ (srst_b),
        .SRST_ACK (ack_b),
        .DIV      (div_b),
        .CH_RSTn  (rstn_b),
        .CH_CE    (ce_b),
        .READY    (ready_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Default timing: channel i released on edge 17+8*i after reset.
    function automatic logic [3:0] exp_rstn(input int e);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (e >= 17 + 8 * i);
        return v;
    endfunction

    // Ratios ch0=0, ch1=3, ch2=5 switching to 2 after the wrap at edge sw, ch3=2.
    function automatic logic [3:0] exp_ce(input int e, input int sw);
        logic [3:0] v;
        v[0] = (e >= 17);
        v[1] = (e > 25) && ((e - 25) % 3 == 0);
        if (e <= sw) v[2] = (e > 33) && ((e - 33) % 5 == 0);
        else         v[2] = ((e - sw) % 2 == 0);
        v[3] = (e > 41) && ((e - 41) % 2 == 0);
        return v;
    endfunction

    task automatic step_a(input int e, input int sw);
        tick();
        chk($sformatf("rstn_e%0d", e),  32'(rstn_a),  32'(exp_rstn(e)));
        chk($sformatf("ce_e%0d", e),    32'(ce_a),    32'(exp_ce(e, sw)));
        chk($sformatf("ready_e%0d", e), 32'(ready_a), 32'(e >= 42));
        chk($sformatf("ack_e%0d", e),   32'(ack_a),   32'd0);
    endtask

    task automatic chk_all_low(input string tag, input logic ack_exp);
        chk({tag, "_rstn"},  32'(rstn_a),  32'd0);
        chk({tag, "_ce"},    32'(ce_a),    32'd0);
        chk({tag, "_ready"}, 32'(ready_a), 32'd0);
        chk({tag, "_ack"},   32'(ack_a),   32'(ack_exp));
    endtask

    initial begin
        RST    = 1'b1;
        srst_a = 1'b0;
        srst_b = 1'b0;
        div_a  = {8'd2, 8'd5, 8'd3, 8'd0};
        div_b  = {8'd1, 8'd1, 8'd1, 8'd1};
        repeat (3) tick();
        chk_all_low("reset", 1'b0);
        chk("reset_b_rstn", 32'(rstn_b), 32'd0);
        RST = 1'b0;

        // Power-on sequence; soft reset during RELEASE ignored; ch2 ratio 5->2 mid-count.
        for (int e = 1; e <= 60; e++) begin
            srst_a = (e >= 18 && e <= 35);
            if (e == 51) div_a[23:16] = 8'd2;
            step_a(e, 53);
            chk($sformatf("b_rstn_e%0d", e),  32'(rstn_b),  (e >= 5) ? 32'hF : 32'h0);
            chk($sformatf("b_ce_e%0d", e),    32'(ce_b),    (e >= 5) ? 32'hF : 32'h0);
            chk($sformatf("b_ready_e%0d", e), 32'(ready_b), 32'(e >= 6));
            chk($sformatf("b_ack_e%0d", e),   32'(ack_b),   32'd0);
        end

        // One-cycle soft reset in RUN, then the sequence repeats with the same offsets.
        srst_a = 1'b1;
        tick();
        chk_all_low("srst_edge", 1'b1);
        srst_a = 1'b0;
        tick();
        chk_all_low("srst_exit", 1'b0);
        for (int e = 1; e <= 45; e++) step_a(e, 33);

        // Request held high: exactly one ACK per full HOLD/RELEASE/RUN pass.
        srst_a = 1'b1;
        tick();
        chk_all_low("hold_req_ack1", 1'b1);
        tick();
        chk_all_low("hold_req_exit", 1'b0);
        for (int e = 1; e <= 41; e++) step_a(e, 33);
        tick();
        chk_all_low("hold_req_ack2", 1'b1);
        srst_a = 1'b0;
        tick();
        chk_all_low("hold_req_done", 1'b0);

        // Hard reset mid-RELEASE restarts everything.
        RST = 1'b1;
        repeat (3) tick();
        chk_all_low("rst2", 1'b0);
        RST = 1'b0;
        for (int e = 1; e <= 30; e++) step_a(e, 33);
        RST = 1'b1;
        tick();
        chk_all_low("rst_mid", 1'b0);
        RST = 1'b0;
        for (int e = 1; e <= 42; e++) step_a(e, 33);

        // RST and SRST_REQ together in RUN: reset wins, no ACK.
        RST    = 1'b1;
        srst_a = 1'b1;
        tick();
        chk_all_low("rst_vs_srst", 1'b0);
        RST    = 1'b0;
        srst_a = 1'b0;
        tick();
        chk_all_low("rst_vs_srst_next", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
